inst_rom_wait: RTL and testbench
================================

// Module: inst_rom_wait
// PURPOSE
//   Parametrised instruction memory for the pipeline SoC: replaces the zero-latency
//   combinational ROM with a WAIT_CYCLES-latency fetch unit that drives a stall request.
//   Sits between PipeLine (rom_ce_o/rom_addr_o/rom_data_i) and the instruction array.
//   Flags misaligned and out-of-range fetches. Counts completed fetches.
// PARAMETERS
//   DATA_W       32        instruction width
//   ADDR_W       32        byte-address width
//   DEPTH_LOG2   10        log2 of word count; array inst_mem[0:2**DEPTH_LOG2-1]
//   WAIT_CYCLES  2         extra latency cycles, legal 0..15
//   NOP_INST     32'h0     word returned on fault or while not valid
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active-high
//   ce         in   1       fetch enable, from rom_ce_o
//   addr       in   ADDR_W  byte address, from rom_addr_o
//   inst       out  DATA_W  instruction, to rom_data_i
//   inst_valid out  1       inst holds the response for addr_q this cycle
//   stall_req  out  1       pipeline must hold PC/IF-ID this cycle
//   fault      out  1       response is misaligned/out-of-range (qualified by inst_valid)
//   fetch_cnt  out  32      completed fetches, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
//   - One clock, synchronous active-high rst. Reset: state IDLE, addr_q=0, cnt=0,
//     inst_q=NOP_INST, fault=0, inst_valid=0, fetch_cnt=0; stall_req forced 0 while rst.
//   - inst_mem is a plain reg array named inst_mem, preloaded by $readmemh from the bench.
//   - Index = addr[DEPTH_LOG2+1:2]. Fault if addr[1:0]!=0 or addr[ADDR_W-1:DEPTH_LOG2+2]!=0.
//   - Accept = latch addr_q<=addr, cnt<=WAIT_CYCLES; next state WAIT if WAIT_CYCLES>0 else DONE.
//   - IDLE: ce=1 -> accept. ce=0 -> stay.
//   - WAIT: ce=0 -> IDLE (abandon, no response). ce=1 & addr!=addr_q -> re-accept new addr
//     (redirect/flush; old fetch discarded). Else cnt decrements; at cnt==1 -> DONE, loading
//     inst_q<=fault?NOP_INST:inst_mem[index], fault reg<=fault(addr_q).
//     WAIT_CYCLES=0: the IDLE->DONE transition performs that load directly.
//   - DONE: inst_valid=1. ce=1 & addr==addr_q -> consumed: fetch_cnt++ (saturating), -> IDLE.
//     ce=1 & addr!=addr_q -> re-accept (no count). ce=0 -> IDLE (no count).
//   - Latency: accept at cycle T -> inst_valid at T+WAIT_CYCLES+1. Sequential issue rate one
//     instruction per WAIT_CYCLES+2 cycles (IDLE bubble after each consume).
//   - stall_req = !rst & ce & !(state==DONE & addr==addr_q). Combinational, no cycle delay.
//   - inst = ce ? (inst_valid ? inst_q : NOP_INST) : 0 (ce=0 returns zero, as the old ROM did).
//   - fault output = inst_valid & fault reg; 0 otherwise.
//   - rst mid-WAIT/DONE: next cycle IDLE, no inst_valid, no count; pending fetch is lost.
//   - ce and addr changing simultaneously in DONE: a different addr always wins as a new accept.
// TESTING
//   1. WAIT_CYCLES=2, inst_mem[0]=32'h3401_1100, ce=1 addr=0 from T -> stall_req=1 T..T+2,
//      T+3: inst_valid=1, inst=32'h3401_1100, stall_req=0; T+4 IDLE; fetch_cnt=1.
//   2. PipeLine + inst_rom_wait, 3 sequential ori instructions at 0,4,8 -> regfile results match
//      zero-wait run; responses 4 cycles apart; fetch_cnt=3.
//   3. Redirect: addr=0 at T, addr=0x10 at T+1 -> no response for 0; inst=inst_mem[4] at T+4.
//   4. Faults (DEPTH_LOG2=10): addr=0x2 -> inst_valid=1, fault=1, inst=NOP_INST;
//      addr=0x1000 -> fault=1; addr=0xFFC -> fault=0, inst=inst_mem[1023].
//   5. rst=1 at T+1 of fetch from T -> T+2 onward inst_valid=0, stall_req=0 with rst,
//      fetch_cnt=0; after release, fresh fetch completes normally.
//   6. WAIT_CYCLES=0: accept at T -> inst_valid at T+1; ce=0 any cycle -> inst=0, stall_req=0.

Source files
------------

// File: rtl/inst_rom_wait.sv
// inst_rom_wait: instruction memory with a configurable fetch latency.
// Sits between the pipeline fetch port and the instruction array. While a
// fetch is outstanding it raises stall_req so the pipeline holds PC and IF/ID.
// Misaligned or out-of-range fetches complete with NOP_INST and a fault flag.
// Every response the pipeline actually consumes is counted in fetch_cnt.
module inst_rom_wait #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_LOG2  = 10,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] NOP_INST    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              stall_req,
  output logic              fault,
  output logic [31:0]       fetch_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // Instruction array, preloaded from outside; the design only ever reads it.
  reg [DATA_W-1:0] inst_mem [0:(1 << DEPTH_LOG2) - 1];

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     inst_q;
  logic                  fault_q;
  logic [31:0]           fetch_cnt_q;
  logic                  load;
  logic                  consume;
  logic                  load_fault;
  logic [DATA_W-1:0]     load_word;
  logic [DEPTH_LOG2-1:0] load_idx;
  logic                  addr_hit;

  // A fetch faults when it is not word aligned or lies beyond the array.
  function automatic logic is_fault(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != '0);
  endfunction

  assign addr_hit = (addr == addr_q);

  // Next-state logic; a different address always restarts the fetch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ce) begin
          addr_d = addr;
          cnt_d  = WAIT_INIT;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DONE;
            load    = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!ce) begin
          state_d = ST_IDLE;
        end else if (!addr_hit) begin
          addr_d = addr;
          cnt_d  = WAIT_INIT;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DONE;
            load    = 1'b1;
          end
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!ce) begin
          state_d = ST_IDLE;
        end else if (!addr_hit) begin
          addr_d = addr;
          cnt_d  = WAIT_INIT;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DONE;
            load    = 1'b1;
          end
        end else begin
          consume = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The word loaded always belongs to the address held after this edge.
  always_comb begin
    load_idx   = addr_d[DEPTH_LOG2+1:2];
    load_fault = is_fault(addr_d);
    load_word  = load_fault ? NOP_INST : inst_mem[load_idx];
  end

  // Fetch state, latched address and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response register, filled on the cycle the fetch completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      fault_q <= 1'b0;
    end else if (load) begin
      inst_q  <= load_word;
      fault_q <= load_fault;
    end
  end

  // Saturating count of responses the pipeline consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
    end else if (consume && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  // Output decode; ce low returns zero like the old combinational ROM.
  always_comb begin
    inst_valid = (state_q == ST_DONE);
    stall_req  = !rst && ce && !(inst_valid && addr_hit);
    fault      = inst_valid && fault_q;
    fetch_cnt  = fetch_cnt_q;
    if (!ce) begin
      inst = '0;
    end else if (inst_valid) begin
      inst = inst_q;
    end else begin
      inst = NOP_INST;
    end
  end

endmodule

// File: tb/tb_inst_rom_wait.sv
// tb_inst_rom_wait: directed bench for inst_rom_wait with a response scoreboard.
// dut uses WAIT_CYCLES=2, dut1 uses WAIT_CYCLES=0; both share clock and reset.
module tb_inst_rom_wait;

  localparam int W0 = 2;

  typedef struct {
    logic [31:0] inst;
    logic        fault;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall_req;
  logic        fault;
  logic [31:0] fetch_cnt;

  logic        ce1;
  logic [31:0] addr1;
  logic [31:0] inst1;
  logic        inst_valid1;
  logic        stall_req1;
  logic        fault1;
  logic [31:0] fetch_cnt1;

  int    checks;
  int    failures;
  resp_t sb_q[$];

  inst_rom_wait #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W0), .NOP_INST(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .inst_valid(inst_valid), .stall_req(stall_req), .fault(fault), .fetch_cnt(fetch_cnt)
  );

  inst_rom_wait #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0), .NOP_INST(32'h0)
  ) dut1 (
    .clk(clk), .rst(rst), .ce(ce1), .addr(addr1), .inst(inst1),
    .inst_valid(inst_valid1), .stall_req(stall_req1), .fault(fault1), .fetch_cnt(fetch_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit in case something waits forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive dut inputs just after the edge, then settle mid-cycle and score any response.
  task automatic applyStimulus(input logic rst_v, input logic ce_v, input logic [31:0] addr_v);
    resp_t r;
    @(posedge clk);
    #1;
    rst  = rst_v;
    ce   = ce_v;
    addr = addr_v;
    @(negedge clk);
    if (inst_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected", 32'(sb_q.size()), 32'd1);
      end else begin
        r = sb_q.pop_front();
        checkOutput("sb_inst", inst, ce ? r.inst : 32'h0);
        checkOutput("sb_fault", {31'b0, fault}, {31'b0, r.fault});
      end
    end
  endtask

  task automatic applyStimulus1(input logic ce_v, input logic [31:0] addr_v);
    @(posedge clk);
    #1;
    ce1   = ce_v;
    addr1 = addr_v;
    @(negedge clk);
  endtask

  // Hold ce/addr until the response shows up, and check the fetch latency.
  task automatic run_fetch(input logic [31:0] a, input logic [31:0] exp_inst,
                           input logic exp_fault, input string tag);
    resp_t r;
    int    n;
    r.inst  = exp_inst;
    r.fault = exp_fault;
    sb_q.push_back(r);
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b1, a);
      n++;
    end while (!inst_valid && n < 12);
    checkOutput({tag, "_latency"}, 32'(n), 32'(W0 + 2));
    checkOutput({tag, "_stall"}, {31'b0, stall_req}, 32'd0);
  endtask

  initial begin
    resp_t r;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    ce    = 1'b0;
    addr  = 32'h0;
    ce1   = 1'b0;
    addr1 = 32'h0;
    dut.inst_mem[0]     = 32'h3401_1100;
    dut.inst_mem[1]     = 32'h3402_0020;
    dut.inst_mem[2]     = 32'h3403_FF00;
    dut.inst_mem[4]     = 32'hAAAA_5555;
    dut.inst_mem[1023]  = 32'hDEAD_BEEF;
    dut1.inst_mem[0]    = 32'h0BAD_F00D;
    dut1.inst_mem[3]    = 32'h1234_5678;

    // Reset: stall forced low even with ce high, then idle outputs.
    applyStimulus(1'b1, 1'b1, 32'h0);
    checkOutput("rst_stall", {31'b0, stall_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("reset_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("reset_fault", {31'b0, fault}, 32'd0);
    checkOutput("reset_stall", {31'b0, stall_req}, 32'd0);
    checkOutput("reset_inst", inst, 32'h0);
    checkOutput("reset_cnt", fetch_cnt, 32'd0);
    checkOutput("reset_cnt1", fetch_cnt1, 32'd0);

    // Single fetch with explicit cycle-by-cycle timing.
    r.inst  = 32'h3401_1100;
    r.fault = 1'b0;
    sb_q.push_back(r);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("t1_stall_T0", {31'b0, stall_req}, 32'd1);
    checkOutput("t1_valid_T0", {31'b0, inst_valid}, 32'd0);
    checkOutput("t1_inst_T0", inst, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("t1_stall_T1", {31'b0, stall_req}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("t1_stall_T2", {31'b0, stall_req}, 32'd1);
    checkOutput("t1_valid_T2", {31'b0, inst_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("t1_valid_T3", {31'b0, inst_valid}, 32'd1);
    checkOutput("t1_stall_T3", {31'b0, stall_req}, 32'd0);
    checkOutput("t1_inst_T3", inst, 32'h3401_1100);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_cnt", fetch_cnt, 32'd1);
    checkOutput("t1_idle_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("t1_idle_inst", inst, 32'h0);

    // Sequential fetches, one every W0+2 cycles.
    run_fetch(32'h0, 32'h3401_1100, 1'b0, "seq0");
    run_fetch(32'h4, 32'h3402_0020, 1'b0, "seq4");
    run_fetch(32'h8, 32'h3403_FF00, 1'b0, "seq8");
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("seq_cnt", fetch_cnt, 32'd4);

    // Redirect during WAIT: the fetch of 0 is dropped, 0x10 completes.
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("redir_stall", {31'b0, stall_req}, 32'd1);
    run_fetch(32'h10, 32'hAAAA_5555, 1'b0, "redir");

    // Fault and boundary addresses.
    run_fetch(32'h2, 32'h0, 1'b1, "misalign");
    run_fetch(32'h1000, 32'h0, 1'b1, "range");
    run_fetch(32'hFFC, 32'hDEAD_BEEF, 1'b0, "last");
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("fault_cnt", fetch_cnt, 32'd8);
    checkOutput("fault_idle", {31'b0, fault}, 32'd0);

    // Abandon during WAIT: no response may ever appear.
    applyStimulus(1'b0, 1'b1, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h8);
    checkOutput("abandon_stall", {31'b0, stall_req}, 32'd0);
    checkOutput("abandon_inst", inst, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("abandon_cnt", fetch_cnt, 32'd8);

    // ce dropped while DONE: response visible but zeroed, not counted.
    r.inst  = 32'h3402_0020;
    r.fault = 1'b0;
    sb_q.push_back(r);
    for (int i = 0; i < W0 + 1; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h4);
    end
    applyStimulus(1'b0, 1'b0, 32'h4);
    checkOutput("done_ce0_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("done_ce0_stall", {31'b0, stall_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h4);
    checkOutput("done_ce0_idle", {31'b0, inst_valid}, 32'd0);
    checkOutput("done_ce0_cnt", fetch_cnt, 32'd8);

    // Reset in the middle of a fetch loses it and clears the count.
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0);
    checkOutput("midrst_stall", {31'b0, stall_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0);
    checkOutput("midrst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("midrst_stall2", {31'b0, stall_req}, 32'd0);
    checkOutput("midrst_cnt", fetch_cnt, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    run_fetch(32'h4, 32'h3402_0020, 1'b0, "postrst");
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("postrst_cnt", fetch_cnt, 32'd1);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    // Zero-wait instance: response on the cycle after accept.
    applyStimulus1(1'b1, 32'hC);
    checkOutput("w0_stall_T0", {31'b0, stall_req1}, 32'd1);
    checkOutput("w0_valid_T0", {31'b0, inst_valid1}, 32'd0);
    applyStimulus1(1'b1, 32'hC);
    checkOutput("w0_valid_T1", {31'b0, inst_valid1}, 32'd1);
    checkOutput("w0_inst_T1", inst1, 32'h1234_5678);
    checkOutput("w0_stall_T1", {31'b0, stall_req1}, 32'd0);
    checkOutput("w0_fault_T1", {31'b0, fault1}, 32'd0);
    applyStimulus1(1'b0, 32'hC);
    checkOutput("w0_ce0_inst", inst1, 32'h0);
    checkOutput("w0_ce0_stall", {31'b0, stall_req1}, 32'd0);
    checkOutput("w0_cnt", fetch_cnt1, 32'd1);
    applyStimulus1(1'b1, 32'h0);
    applyStimulus1(1'b0, 32'h0);
    checkOutput("w0_done_ce0_valid", {31'b0, inst_valid1}, 32'd1);
    checkOutput("w0_done_ce0_inst", inst1, 32'h0);
    checkOutput("w0_done_ce0_stall", {31'b0, stall_req1}, 32'd0);
    applyStimulus1(1'b0, 32'h0);
    checkOutput("w0_cnt_final", fetch_cnt1, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
